// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM encoding for the vectoring-mode CORDIC.
package cordic_pkg;

    // Angles in Q4.14 radians, gain constant in Q0.16.
    localparam int          PI_HALF = 25736;
    localparam int          PI      = 51472;
    // +pi expressed directly in the Q3.13 phase format.
    localparam int          PI_Q13  = 25736;
    localparam int unsigned K_Q16   = 39797;

    typedef enum logic [1:0] {
        StIdle,
        StRot,
        StScale,
        StOut
    } state_e;

    // atan(2^-i) in Q4.14; zero past the last meaningful entry.
    function automatic int atan_q14(input int unsigned i);
        int a;
        a = 0;
        case (i)
            0:  a = 'h3243;
            1:  a = 'h1DAC;
            2:  a = 'h0FAD;
            3:  a = 'h07F5;
            4:  a = 'h03FE;
            5:  a = 'h01FF;
            6:  a = 'h00FF;
            7:  a = 'h007F;
            8:  a = 'h003F;
            9:  a = 'h001F;
            10: a = 'h0010;
            11: a = 'h0008;
            12: a = 'h0004;
            13: a = 'h0002;
            14: a = 'h0001;
            default: a = 0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero and accumulates angle in z.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int unsigned W  = 18,
    parameter int unsigned SW = 4
) (
    input  logic signed [W-1:0]  x_i,
    input  logic signed [W-1:0]  y_i,
    input  logic signed [W-1:0]  z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic signed [W-1:0]  atan_i,
    output logic signed [W-1:0]  x_o,
    output logic signed [W-1:0]  y_o,
    output logic signed [W-1:0]  z_o
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    always_comb begin
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        if (!y_i[W-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude, atan2(y, x)), one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain from mag.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   mag,
    output logic [N-1:0] phase
);

    localparam int unsigned W  = N + 2;
    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [W-1:0] PI_HALF_W = W'(PI_HALF);
    localparam logic signed [N-1:0] PH_MAX    = N'(PI_Q13);
    localparam logic signed [N-1:0] PH_MIN    = N'(1 - PI_Q13);

    state_e              state_q;
    logic signed [W-1:0] x_q, y_q, z_q;
    logic [IW-1:0]       iter_q;
    logic                axis_q;
    logic                neg_q;

    logic signed [W-1:0] x_ext, y_ext;
    logic signed [W-1:0] x_pre, y_pre, z_pre;
    logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [W-1:0] atan;
    logic signed [N-1:0] z_trunc;
    logic signed [N-1:0] phase_nxt;

    assign x_ext = {{2{x_in[N-1]}}, x_in};
    assign y_ext = {{2{y_in[N-1]}}, y_in};

    // Fold the left half-plane into the right so the iterations always converge.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[N-1]) begin
            if (!y_in[N-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = PI_HALF_W;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = -PI_HALF_W;
            end
        end
    end

    assign atan = W'(atan_q14(32'(iter_q)));

    cordic_vec_stage #(
        .W  (W),
        .SW (IW)
    ) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (iter_q),
        .atan_i  (atan),
        .x_o     (x_nxt),
        .y_o     (y_nxt),
        .z_o     (z_nxt)
    );

    // Real-axis inputs get exact phases; elsewhere clamp rounding spill into (-pi, +pi].
    always_comb begin
        z_trunc   = z_nxt[N:1];
        phase_nxt = z_trunc;
        if (z_trunc > PH_MAX) begin
            phase_nxt = PH_MAX;
        end else if (z_trunc < PH_MIN) begin
            phase_nxt = PH_MIN;
        end
        if (axis_q) begin
            phase_nxt = neg_q ? PH_MAX : '0;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic [N+16:0] prod;
    assign prod = {16'b0, x_q[N:0]} * (N+17)'(K_Q16);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            iter_q    <= '0;
            axis_q    <= 1'b0;
            neg_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag       <= '0;
            phase     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q      <= x_pre;
                        y_q      <= y_pre;
                        z_q      <= z_pre;
                        iter_q   <= '0;
                        axis_q   <= (y_in == '0);
                        neg_q    <= x_in[N-1];
                        in_ready <= 1'b0;
                        state_q  <= StRot;
                    end
                end
                StRot: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    if (iter_q == IW'(ITER - 1)) begin
                        phase <= phase_nxt;
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= StScale;
`else
                        mag       <= x_nxt[N:0];
                        out_valid <= 1'b1;
                        state_q   <= StOut;
`endif
                    end else begin
                        iter_q <= iter_q + 1'b1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                StScale: begin
                    mag       <= (N+1)'(prod >> 16);
                    out_valid <= 1'b1;
                    state_q   <= StOut;
                end
`endif
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
